// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard slot layout,
// forwarding select encoding and the empty-slot constant used for bubbles.
package hazard_pkg;

  localparam int REG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic                writes_rd;
    logic [REG_ID_W-1:0] rd;
    logic                is_load;
    logic                sets_flags;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  localparam sb_entry_t SB_NOP = '{
    valid:      1'b0,
    writes_rd:  1'b0,
    rd:         {REG_ID_W{1'b0}},
    is_load:    1'b0,
    sets_flags: 1'b0
  };

endpackage

// File: rtl/hazard_match.sv
// Combinational RAW check of one ID read register against one scoreboard slot.
module hazard_match
  import hazard_pkg::*;
(
  input  sb_entry_t           slot_i,
  input  logic [REG_ID_W-1:0] rs_i,
  input  logic                uses_i,
  output logic                hit_o
);

  assign hit_o = uses_i && slot_i.valid && slot_i.writes_rd && (slot_i.rd == rs_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: scoreboard, IF/ID stall,
// redirect squash and stall counter. Define HAZARD_FORWARD_EN to add EX operand forwarding.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ID_LEN    = REG_ID_W,
  parameter int STALL_CNT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_ID_LEN-1:0]    id_rs1,
  input  logic [REG_ID_LEN-1:0]    id_rs2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     id_writes_rd,
  input  logic [REG_ID_LEN-1:0]    id_rd,
  input  logic                     id_is_load,
  input  logic                     id_sets_flags,
  input  logic                     id_uses_flags,
  input  logic                     id_redirect,
  output logic                     pc_ld,
  output logic                     pr1_hold,
  output logic                     pr1_flush,
  output logic                     pr2_bubble,
`ifdef HAZARD_FORWARD_EN
  output logic [1:0]               fwd_sel_a,
  output logic [1:0]               fwd_sel_b,
`endif
  output logic [STALL_CNT_LEN-1:0] stall_count
);

  // Slot 0 = EX, 1 = MEM, 2 = WB
  sb_entry_t                slot_q [3];
  sb_entry_t                ex_d;
  logic [2:0]               hit_a_s;
  logic [2:0]               hit_b_s;
  logic                     reg_stall_s;
  logic                     flag_stall_s;
  logic                     stall_s;
  logic [STALL_CNT_LEN-1:0] cnt_q;
  logic [STALL_CNT_LEN-1:0] cnt_d;
  logic                     unused_slot_bits;

  for (genvar s = 0; s < 3; s++) begin : g_match
    hazard_match u_match_a (
      .slot_i (slot_q[s]),
      .rs_i   (id_rs1),
      .uses_i (id_uses_rs1),
      .hit_o  (hit_a_s[s])
    );
    hazard_match u_match_b (
      .slot_i (slot_q[s]),
      .rs_i   (id_rs2),
      .uses_i (id_uses_rs2),
      .hit_o  (hit_b_s[s])
    );
  end

  // MEM/WB flag and load attributes only ride along for pipeline bookkeeping
  assign unused_slot_bits = ^{slot_q[0].is_load, slot_q[1].is_load, slot_q[1].sets_flags,
                              slot_q[2].is_load, slot_q[2].sets_flags};

`ifdef HAZARD_FORWARD_EN
  // A load result is not available for forwarding until it reaches MEM; WB writes too late
  assign reg_stall_s = ((hit_a_s[0] || hit_b_s[0]) && slot_q[0].is_load) ||
                       hit_a_s[2] || hit_b_s[2];
`else
  assign reg_stall_s = (|hit_a_s) || (|hit_b_s);
`endif

  assign flag_stall_s = id_uses_flags && slot_q[0].valid && slot_q[0].sets_flags;
  assign stall_s      = !rst && id_valid && (reg_stall_s || flag_stall_s);

  // Next EX slot: the ID instruction when it advances, otherwise a bubble
  always_comb begin
    ex_d = SB_NOP;
    if (id_valid && !stall_s) begin
      ex_d = '{valid: 1'b1, writes_rd: id_writes_rd, rd: id_rd,
               is_load: id_is_load, sets_flags: id_sets_flags};
    end else begin
      ex_d = SB_NOP;
    end
  end

  // Scoreboard shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= SB_NOP;
      slot_q[1] <= SB_NOP;
      slot_q[2] <= SB_NOP;
    end else begin
      slot_q[0] <= ex_d;
      slot_q[1] <= slot_q[0];
      slot_q[2] <= slot_q[1];
    end
  end

  // Pipeline register controls; redirect is only honoured once the stall clears
  always_comb begin
    pc_ld      = 1'b1;
    pr1_hold   = 1'b0;
    pr1_flush  = 1'b0;
    pr2_bubble = 1'b0;
    if (stall_s) begin
      pc_ld      = 1'b0;
      pr1_hold   = 1'b1;
      pr2_bubble = 1'b1;
    end else if (!rst && id_valid && id_redirect) begin
      pr1_flush = 1'b1;
    end else begin
      pr1_flush = 1'b0;
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    cnt_d = cnt_q;
    if (stall_s && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(STALL_CNT_LEN-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {STALL_CNT_LEN{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

`ifdef HAZARD_FORWARD_EN
  fwd_sel_t fwd_a_s, fwd_b_s, fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

  // Operand source selection; the youngest producer (EX) wins
  always_comb begin
    fwd_a_s = FWD_RF;
    fwd_b_s = FWD_RF;
    if (hit_a_s[0]) begin
      fwd_a_s = FWD_EXMEM;
    end else if (hit_a_s[1]) begin
      fwd_a_s = FWD_MEMWB;
    end else begin
      fwd_a_s = FWD_RF;
    end
    if (hit_b_s[0]) begin
      fwd_b_s = FWD_EXMEM;
    end else if (hit_b_s[1]) begin
      fwd_b_s = FWD_MEMWB;
    end else begin
      fwd_b_s = FWD_RF;
    end
  end

  // Selects travel with the instruction into EX; bubbles read the register file
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (id_valid && !stall_s) begin
      fwd_a_d = fwd_a_s;
      fwd_b_d = fwd_b_s;
    end else begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (both HAZARD_FORWARD_EN builds).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam int ALU_STALLS  = 0;
  localparam int LOAD_STALLS = 1;
`else
  localparam int ALU_STALLS  = 3;
  localparam int LOAD_STALLS = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic        id_is_load, id_sets_flags, id_uses_flags, id_redirect;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic        pc_ld, pr1_hold, pr1_flush, pr2_bubble;
  logic        s_pc_ld, s_pr1_hold, s_pr1_flush, s_pr2_bubble;
  logic [15:0] stall_count;
  logic [2:0]  s_stall_count;
`ifdef HAZARD_FORWARD_EN
  logic [1:0]  fwd_sel_a, fwd_sel_b, s_fwd_sel_a, s_fwd_sel_b;
`endif

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .id_rd(id_rd), .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
    .id_uses_flags(id_uses_flags), .id_redirect(id_redirect),
    .pc_ld(pc_ld), .pr1_hold(pr1_hold), .pr1_flush(pr1_flush), .pr2_bubble(pr2_bubble),
`ifdef HAZARD_FORWARD_EN
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
`endif
    .stall_count(stall_count)
  );

  // Narrow counter instance shares the stimulus to exercise saturation quickly
  pipeline_hazard_ctrl #(.STALL_CNT_LEN(3)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .id_rd(id_rd), .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
    .id_uses_flags(id_uses_flags), .id_redirect(id_redirect),
    .pc_ld(s_pc_ld), .pr1_hold(s_pr1_hold), .pr1_flush(s_pr1_flush), .pr2_bubble(s_pr2_bubble),
`ifdef HAZARD_FORWARD_EN
    .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b),
`endif
    .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic instr(input logic v, input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2, input logic wr,
                       input logic [2:0] rd, input logic ld, input logic sf,
                       input logic uf, input logic rdr);
    id_valid = v;   id_rs1 = rs1;  id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_writes_rd = wr; id_rd = rd; id_is_load = ld; id_sets_flags = sf;
    id_uses_flags = uf; id_redirect = rdr;
  endtask

  task automatic nop();
    instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check the control outputs for this cycle, then advance to the next negedge
  task automatic step(input logic exp_stall, input logic exp_flush);
    #1;
    chk("pc_ld", {31'd0, pc_ld}, {31'd0, !exp_stall});
    chk("pr1_hold", {31'd0, pr1_hold}, {31'd0, exp_stall});
    chk("pr1_flush", {31'd0, pr1_flush}, {31'd0, exp_flush});
    chk("pr2_bubble", {31'd0, pr2_bubble}, {31'd0, exp_stall});
    if (exp_stall) exp_cnt++;
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, {16'd0, stall_count}, exp_cnt);
    chk({tag, "_sat"}, {29'd0, s_stall_count}, (exp_cnt > 7) ? 32'd7 : exp_cnt);
  endtask

  task automatic drain();
    nop();
    repeat (3) step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    // Hazard-looking inputs during reset must not disturb the outputs
    instr(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk_cnt("reset_cnt");

    // Independent instructions: no stall
    instr(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    instr(1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    drain();
    chk_cnt("indep_cnt");

    // ADD r1 then SUB r4 <- r1, r5
    instr(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    instr(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (ALU_STALLS) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`ifdef HAZARD_FORWARD_EN
    chk("alu_fwd_a", {30'd0, fwd_sel_a}, 32'd1);
    chk("alu_fwd_b", {30'd0, fwd_sel_b}, 32'd0);
`endif
    drain();
`ifdef HAZARD_FORWARD_EN
    chk("bubble_fwd_a", {30'd0, fwd_sel_a}, 32'd0);
`endif
    chk_cnt("alu_cnt");

    // LOAD r2 then ADD r3 <- r2, r2
    instr(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    instr(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (LOAD_STALLS) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`ifdef HAZARD_FORWARD_EN
    chk("load_fwd_a", {30'd0, fwd_sel_a}, 32'd2);
    chk("load_fwd_b", {30'd0, fwd_sel_b}, 32'd2);
`endif
    drain();
    chk_cnt("load_cnt");

    // Flag-setting ADD then taken conditional branch on C
    instr(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    nop();
    step(1'b0, 1'b0);
    drain();
    chk_cnt("flag_cnt");

    // Redirect reading a register still being loaded: flush only after the stall
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    instr(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (LOAD_STALLS) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    nop();
    step(1'b0, 1'b0);
    drain();
    chk_cnt("redir_cnt");

    // Fill EX/MEM/WB, stall on the WB writer, then reset mid-stall
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    id_rd = 3'd2;
    step(1'b0, 1'b0);
    id_rd = 3'd3;
    step(1'b0, 1'b0);
    instr(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_cnt("prerst_cnt");
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    exp_cnt = 0;
    step(1'b0, 1'b0);
    chk_cnt("postrst_cnt");
    drain();

    // Repeated load-use pairs push the narrow counter into saturation
    for (int i = 0; i < 8; i++) begin
      instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0);
      instr(1'b1, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (LOAD_STALLS) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      drain();
    end
    chk_cnt("sat_cnt");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage 8-bit pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight register writers in a 3-slot scoreboard (EX, MEM, WB) and stalls IF/ID on RAW register and flag hazards.
- Squashes the IF/ID register on ID-resolved redirects (jump, taken branch, call/return).
- Sits beside the controller in ID and drives PC load enable, PR1 hold/flush and PR2 bubble insert.

Parameters:
- REG_ID_LEN, 3, register-file ID width.
- STALL_CNT_LEN, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  PR1 holds a real instruction
- id_rs1  in  REG_ID_LEN  first read register (instruction bits 10:8)
- id_rs2  in  REG_ID_LEN  second read register (output of the reg2-source mux)
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_writes_rd  in  1  instruction writes the register file
- id_rd  in  REG_ID_LEN  destination register (bits 13:11)
- id_is_load  in  1  writeback source is data memory
- id_sets_flags  in  1  instruction loads C/Z in EX
- id_uses_flags  in  1  conditional branch or carry-in on C/Z
- id_redirect  in  1  ID selects a PC other than PC+1
- pc_ld  out  1  PC load enable
- pr1_hold  out  1  PR1 keeps its contents
- pr1_flush  out  1  PR1 loads a NOP next edge
- pr2_bubble  out  1  PR2 loads a NOP (all control zero) next edge
- stall_count  out  STALL_CNT_LEN  saturating count of stall cycles

Behaviour:
- Scoreboard slot fields: valid, rd, is_load, sets_flags. Slots are EX, MEM and WB.
- Every edge: WB<=MEM, MEM<=EX. EX loads the ID fields when id_valid && !stall && !id_redirect-squash; otherwise EX.valid<=0.
- A redirect instruction itself still enters EX.
- Register-file writes commit at the WB edge. A reader in ID in the same cycle sees the old value, so a WB-slot match is a hazard.
- match(s, r) = s.valid && s.rd==r && rd-writer. Applies to rs1 when id_uses_rs1 and to rs2 when id_uses_rs2.
- Base stall (feature off): any match in EX, MEM or WB.
- Flag stall: id_uses_flags && EX.valid && EX.sets_flags. C/Z become valid after the EX edge.
- stall = id_valid && (register stall || flag stall).
- While stalled:
  - pc_ld=0, pr1_hold=1, pr2_bubble=1.
  - id_redirect is ignored; redirect is evaluated only when stall=0.
- Redirect (id_valid && id_redirect && !stall):
  - pc_ld=1, pr1_flush=1 for exactly that cycle.
  - The next cycle ID holds the NOP (id_valid=0), giving a one-cycle penalty.
- Normal: pc_ld=1, pr1_hold=0, pr1_flush=0, pr2_bubble=0.
- pr1_flush and pr1_hold are never both 1.
- stall_count increments once per stall cycle and holds at all-ones.
- Reset (any cycle, including mid-stall):
  - all scoreboard slots invalid, stall_count=0.
  - outputs during rst: pc_ld=1, pr1_hold=0, pr1_flush=0, pr2_bubble=0.
  - the first post-reset cycle is never stalled.
- Writes to register 0 are tracked like any other register; there is no hardwired-zero exemption.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- When defined, add outputs fwd_sel_a and fwd_sel_b (2 bits each) for EX operands 1/2:
  - 0 = register file
  - 1 = PR3 ALU out (producer was in the EX slot)
  - 2 = PR4 writeback data (producer was in the MEM slot)
- fwd_sel_a/b are registered: computed in ID and loaded at the edge the consumer enters EX. Reset value 0; value 0 when a bubble enters.
- EX-slot match wins over MEM-slot match.
- With forwarding, stall only for:
  - EX-slot match with is_load (one cycle)
  - WB-slot match
  - the flag hazard
- Undefined: ports are absent and the base stall rules apply.

Decomposition:
- Shared package hazard_pkg:
  - sb_entry_t struct (valid, rd, is_load, sets_flags)
  - fwd_sel_t enum (FWD_RF, FWD_EXMEM, FWD_MEMWB)
  - NOP control constant used for bubble/flush
- One sub-module, hazard_match: combinational compare of one read ID against one slot, instantiated per operand per slot.

Test Plan:
- Reset, then ADD r1<-r2,r3 followed by an independent instruction -> no stall, stall_count=0, pc_ld=1 throughout.
- ADD r1 then SUB r4<-r1,r5 back-to-back (feature off) -> 3 stall cycles, pr2_bubble=1 on each, stall_count=3. Feature on -> 0 stalls, fwd_sel_a=1 when SUB is in EX.
- LOAD r2 then ADD r3<-r2,r2 (feature on) -> exactly 1 stall, then fwd_sel_a=fwd_sel_b=2.
- Flag-setting ADD then conditional branch using C -> 1 stall cycle, then the branch resolves; if taken, pr1_flush=1 for one cycle and the next id_valid=0.
- Redirect asserted while a register hazard is stalling -> no flush until the stall clears, then a single pr1_flush pulse.
- rst asserted during a stall with EX/MEM/WB slots full -> next cycle no stall, all slots invalid, stall_count=0. Preload stall_count near all-ones and stall -> saturates at 16'hFFFF.
